// File: rtl/acc_output_bank.sv
// acc_output_bank: row-wide accumulator/output bank for the systolic array.
// Takes one row of ARR_SIZE partial sums per cycle. Each row either overwrites
// or accumulates into a DEPTH-row bank, with optional saturation. A
// ready/valid port drains single words, and a sweep FSM zeroes the bank
// between tiles.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   mac_valid/mode    - row write strobe; mode 1 = overwrite, 0 = accumulate
//   mac_addr/data     - target row and packed lanes (lane i at [i*DATA_W +: DATA_W])
//   clear_req, busy   - start zero sweep / sweep in progress
//   rd_req/addr/lane  - read request, accepted when rd_req && rd_req_ready
//   rd_req_ready      - request side ready
//   rd_valid/data     - read response, held until rd_ready
//   overflow          - sticky lane overflow (saturate or wrap)
//   drop_err          - sticky dropped-MAC-row flag
module acc_output_bank #(
  parameter int unsigned ARR_SIZE = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned LANE_W   = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mac_valid,
  input  logic                       mac_mode,
  input  logic [ADDR_W-1:0]          mac_addr,
  input  logic [ARR_SIZE*DATA_W-1:0] mac_data,
  input  logic                       clear_req,
  output logic                       busy,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [LANE_W-1:0]          rd_lane,
  output logic                       rd_req_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       rd_ready,
  output logic                       overflow,
  output logic                       drop_err
);

  localparam int unsigned        LANE_N   = 1 << LANE_W;
  localparam logic [DATA_W-1:0]  MAX_W    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]  MIN_W    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0]  LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                          state, next_state;
  logic [ADDR_W-1:0]               clr_row;
  logic [DATA_W-1:0]               bank [DEPTH][ARR_SIZE];

  logic                            clear_acc, clr_we, wr_en, drop;
  logic [ARR_SIZE-1:0][DATA_W:0]   lane_res;
  logic [ARR_SIZE-1:0]             lane_ovf;
  logic                            ovf_any;
  logic [DATA_W-1:0]               lane_mux [LANE_N];
  logic                            rd_accept;

  // One lane update: returns {overflow, new value}.
  function automatic logic [DATA_W:0] lane_update(input logic mode,
                                                  input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] in_w);
    logic [DATA_W:0] sum;
    sum = {old_w[DATA_W-1], old_w} + {in_w[DATA_W-1], in_w};
    if (mode) return {1'b0, in_w};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      if (SATURATE) return {1'b1, (sum[DATA_W] ? MIN_W : MAX_W)};
      return {1'b1, sum[DATA_W-1:0]};
    end
    return {1'b0, sum[DATA_W-1:0]};
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // FSM next state and per-cycle write/clear decisions; clear beats writes
  always_comb begin
    next_state = state;
    clear_acc  = 1'b0;
    clr_we     = 1'b0;
    wr_en      = 1'b0;
    drop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          next_state = S_CLEAR;
          clear_acc  = 1'b1;
          drop       = mac_valid;
        end else begin
          wr_en = mac_valid;
        end
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        drop   = mac_valid;
        if (clr_row == LAST_ROW) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign busy = (state == S_CLEAR);

  // Sweep row pointer, parked at 0 outside the sweep
  always_ff @(posedge clk) begin
    if (reset)                  clr_row <= '0;
    else if (state == S_CLEAR)  clr_row <= clr_row + ADDR_W'(1);
    else                        clr_row <= '0;
  end

  // Per-lane accumulate/overwrite results for the addressed row
  always_comb begin
    lane_res = '0;
    lane_ovf = '0;
    for (int i = 0; i < ARR_SIZE; i++) begin
      lane_res[i] = lane_update(mac_mode, bank[mac_addr][i], mac_data[i*DATA_W +: DATA_W]);
      lane_ovf[i] = lane_res[i][DATA_W];
    end
  end

  assign ovf_any = wr_en && (|lane_ovf);

  // Storage bank
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++)
        for (int i = 0; i < ARR_SIZE; i++)
          bank[r][i] <= '0;
    end else if (clr_we) begin
      for (int i = 0; i < ARR_SIZE; i++)
        bank[clr_row][i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < ARR_SIZE; i++)
        bank[mac_addr][i] <= lane_res[i][DATA_W-1:0];
    end
  end

  // Sticky flags; clear acceptance wins over a same-cycle overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_err <= 1'b0;
    end else if (clear_acc) begin
      overflow <= 1'b0;
      drop_err <= drop;
    end else begin
      if (ovf_any) overflow <= 1'b1;
      if (drop)    drop_err <= 1'b1;
    end
  end

  // Lane select padded to a power of two so unused lane codes read 0
  always_comb begin
    for (int i = 0; i < LANE_N; i++) lane_mux[i] = '0;
    for (int i = 0; i < ARR_SIZE; i++) lane_mux[i] = bank[rd_addr][i];
  end

  assign rd_req_ready = !busy && (!rd_valid || rd_ready);
  assign rd_accept    = rd_req && rd_req_ready;

  // Read response register; samples pre-write bank contents
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      rd_data  <= lane_mux[rd_lane];
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule
